mskaes_128bits_lin_stage: RTL and testbench

//  Masked AES-128 linear stage, directly downstream of the 16-sbox masked SubBytes stage.

---
 rtl/mskaes_128bits_lin_stage.sv | 153 +++++++++++++++
 tb/tb_mskaes_128bits_lin_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_128bits_lin_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mskaes_128bits_lin_stage
//  Brief    : Masked AES-128 linear round stage. Applies ShiftRows,
//             MixColumns (skipped in the final round) and AddRoundKey
//             independently on every share. The result goes out through a
//             registered output with a 2-entry skid buffer. A round counter
//             tags the ciphertext beat.
//  Revision : 1.0 - initial release
// ============================================================================
module mskaes_128bits_lin_stage #(
   parameter int D       = 2,   // number of shares
   parameter int NROUNDS = 10   // AES rounds per block
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [128*D-1:0]     sh_state_in,
   input  logic [128*D-1:0]     sh_rkey_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [128*D-1:0]     sh_state_out,
   output logic                 out_last,
   output logic [3:0]           round_idx
);

   localparam logic [3:0] C_LAST_ROUND = 4'(NROUNDS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [3:0]               r_round, w_round_nxt;

   logic                     w_accept;
   logic                     w_final;
   logic                     w_push;

   // Per-share byte views: [share][byte][bit]
   logic [D-1:0][15:0][7:0]  w_in_b, w_key_b, w_sr_b, w_mc_b, w_res_b;
   logic [128*D-1:0]         w_res_pk;

   logic [128*D-1:0]         r_main, r_skid;
   logic                     r_main_valid, r_skid_valid;
   logic                     r_main_last, r_skid_last;

   // GF(2^8) multiply by x, reduction polynomial 0x11B
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   assign w_accept = in_valid & in_ready;
   assign w_final  = (r_round == C_LAST_ROUND);
   // A beat accepted in IDLE belongs to no block and is silently dropped
   assign w_push   = w_accept & (r_state == S_RUN);

   // Bit-level unpack/repack between the interleaved-share bus and per-share bytes
   for (genvar s = 0; s < D; s++) begin : g_share
      for (genvar i = 0; i < 16; i++) begin : g_byte
         for (genvar b = 0; b < 8; b++) begin : g_bit
            assign w_in_b[s][i][b]          = sh_state_in[8*D*i + D*b + s];
            assign w_key_b[s][i][b]         = sh_rkey_in[8*D*i + D*b + s];
            assign w_res_pk[8*D*i + D*b + s] = w_res_b[s][i][b];
         end
         // ShiftRows: out(r,c) = in(r,(c+r)%4), byte index = r + 4c
         assign w_sr_b[s][i] = w_in_b[s][(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
         // Final round skips MixColumns; the key is always added
         assign w_res_b[s][i] = (w_final ? w_sr_b[s][i] : w_mc_b[s][i]) ^ w_key_b[s][i];
      end
      // MixColumns, circulant [2 3 1 1], computed from this share only
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_mc_b[s][4*c+0] = xt(w_sr_b[s][4*c+0]) ^ xt(w_sr_b[s][4*c+1]) ^ w_sr_b[s][4*c+1]
                                 ^ w_sr_b[s][4*c+2] ^ w_sr_b[s][4*c+3];
         assign w_mc_b[s][4*c+1] = w_sr_b[s][4*c+0] ^ xt(w_sr_b[s][4*c+1]) ^ xt(w_sr_b[s][4*c+2])
                                 ^ w_sr_b[s][4*c+2] ^ w_sr_b[s][4*c+3];
         assign w_mc_b[s][4*c+2] = w_sr_b[s][4*c+0] ^ w_sr_b[s][4*c+1] ^ xt(w_sr_b[s][4*c+2])
                                 ^ xt(w_sr_b[s][4*c+3]) ^ w_sr_b[s][4*c+3];
         assign w_mc_b[s][4*c+3] = xt(w_sr_b[s][4*c+0]) ^ w_sr_b[s][4*c+0] ^ w_sr_b[s][4*c+1]
                                 ^ w_sr_b[s][4*c+2] ^ xt(w_sr_b[s][4*c+3]);
      end
   end

   // Round counter state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_round <= 4'd1;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
      end
   end

   // Next-state: an accept uses the current round; start then overrides the counter
   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      if (w_push) begin
         if (w_final) begin
            w_state_nxt = S_IDLE;          // counter saturates at the last round
         end else begin
            w_round_nxt = r_round + 4'd1;
         end
      end
      if (start) begin
         w_state_nxt = S_RUN;
         w_round_nxt = 4'd1;
      end
   end

   // Output register plus skid entry, drained in FIFO order
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_main       <= '0;
         r_main_valid <= 1'b0;
         r_main_last  <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
         r_skid_last  <= 1'b0;
      end else if (r_skid_valid) begin
         // in_ready is low here, so no new beat can arrive
         if (out_ready) begin
            r_main       <= r_skid;
            r_main_last  <= r_skid_last;
            r_skid_valid <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_main_valid || out_ready) begin
            r_main       <= w_res_pk;
            r_main_last  <= w_final;
            r_main_valid <= 1'b1;
         end else begin
            r_skid       <= w_res_pk;
            r_skid_last  <= w_final;
            r_skid_valid <= 1'b1;
         end
      end else if (out_ready) begin
         r_main_valid <= 1'b0;
      end
   end

   assign in_ready     = !r_skid_valid;
   assign out_valid    = r_main_valid;
   assign sh_state_out = r_main;
   assign out_last     = r_main_last;
   assign round_idx    = r_round;

endmodule
`default_nettype wire

// File: tb/tb_mskaes_128bits_lin_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mskaes_128bits_lin_stage
//  Brief    : Directed self-checking bench for the masked AES linear stage
//             (2 shares, 10 rounds). Values are written as FIPS-197 hex
//             strings, first byte leftmost.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mskaes_128bits_lin_stage;

   localparam int D = 2;

   localparam logic [127:0] C_R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] C_R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] C_R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] C_SR_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] C_MC1_IN  = 128'hdb135345db135345db135345db135345;
   localparam logic [127:0] C_MC1_OUT = 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc;
   localparam logic [127:0] C_MC2_IN  = 128'hf20a225cf20a225cf20a225cf20a225c;
   localparam logic [127:0] C_MC2_OUT = 128'h9fdc589d9fdc589d9fdc589d9fdc589d;
   localparam logic [127:0] C_KA      = 128'h11111111111111111111111111111111;
   localparam logic [127:0] C_KB      = 128'h2222222222222222222222222222222f;
   localparam logic [127:0] C_KC      = 128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c;

   logic                clk;
   logic                nrst;
   logic                start;
   logic                in_valid;
   logic                in_ready;
   logic [128*D-1:0]    sh_state_in;
   logic [128*D-1:0]    sh_rkey_in;
   logic                out_valid;
   logic                out_ready;
   logic [128*D-1:0]    sh_state_out;
   logic                out_last;
   logic [3:0]          round_idx;

   int                  n_checks;
   int                  n_fails;

   mskaes_128bits_lin_stage #(.D(D), .NROUNDS(10)) u_dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sh_state_in  (sh_state_in),
      .sh_rkey_in   (sh_rkey_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sh_state_out (sh_state_out),
      .out_last     (out_last),
      .round_idx    (round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Share 0 = v ^ m, share 1 = m; byte i of the hex string is bus byte i
   function automatic logic [255:0] to_sh(input logic [127:0] v, input logic [127:0] m);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         for (int b = 0; b < 8; b++) begin
            r[16*i + 2*b]     = v[120 - 8*i + b] ^ m[120 - 8*i + b];
            r[16*i + 2*b + 1] = m[120 - 8*i + b];
         end
      return r;
   endfunction

   function automatic logic [127:0] get_share(input logic [255:0] sh, input int s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         for (int b = 0; b < 8; b++)
            r[120 - 8*i + b] = sh[16*i + 2*b + s];
      return r;
   endfunction

   function automatic logic [127:0] unmask(input logic [255:0] sh);
      return get_share(sh, 0) ^ get_share(sh, 1);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One-cycle start pulse; called and returns at posedge+1
   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // One beat presented for exactly one edge; returns at posedge+1
   task automatic send(input logic [255:0] st, input logic [255:0] key);
      in_valid    = 1'b1;
      sh_state_in = st;
      sh_rkey_in  = key;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   logic [127:0] m;
   logic [127:0] km;

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      nrst        = 1'b1;
      start       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      sh_state_in = '0;
      sh_rkey_in  = '0;

      // Reset state
      #2 nrst = 1'b0;
      #2;
      chk_eq("rst_out_valid", 256'(out_valid), 256'(0));
      chk_eq("rst_out_last",  256'(out_last),  256'(0));
      chk_eq("rst_in_ready",  256'(in_ready),  256'(1));
      chk_eq("rst_round_idx", 256'(round_idx), 256'(1));
      chk_eq("rst_data",      sh_state_out,    256'(0));
      @(posedge clk);
      @(posedge clk);
      #1 nrst = 1'b1;

      // Beat in IDLE is dropped
      send(to_sh(C_R1_IN, rnd128()), '0);
      chk_eq("idle_drop_valid", 256'(out_valid), 256'(0));
      chk_eq("idle_drop_ready", 256'(in_ready),  256'(1));
      chk_eq("idle_drop_round", 256'(round_idx), 256'(1));

      // FIPS-197 round 1, masked state and key
      do_start();
      m  = rnd128();
      km = rnd128();
      send(to_sh(C_R1_IN, m), to_sh(C_R1_KEY, km));
      chk_eq("r1_valid", 256'(out_valid), 256'(1));
      chk_eq("r1_data",  256'(unmask(sh_state_out)), 256'(C_R1_OUT));
      chk_eq("r1_last",  256'(out_last), 256'(0));
      chk_eq("r1_round", 256'(round_idx), 256'(2));

      // MixColumns columns (identical columns make ShiftRows transparent)
      send(to_sh(C_MC1_IN, rnd128()), to_sh(128'h0, rnd128()));
      chk_eq("mc1_data", 256'(unmask(sh_state_out)), 256'(C_MC1_OUT));
      send(to_sh(C_MC2_IN, rnd128()), to_sh(128'h0, rnd128()));
      chk_eq("mc2_data", 256'(unmask(sh_state_out)), 256'(C_MC2_OUT));

      // Rounds 4..9
      for (int r = 4; r <= 9; r++) send(to_sh(rnd128(), rnd128()), '0);
      chk_eq("r9_round", 256'(round_idx), 256'(10));

      // Final round: ShiftRows only, tagged last
      send(to_sh(C_R1_IN, rnd128()), to_sh(128'h0, rnd128()));
      chk_eq("r10_data",  256'(unmask(sh_state_out)), 256'(C_SR_OUT));
      chk_eq("r10_last",  256'(out_last), 256'(1));
      chk_eq("r10_round", 256'(round_idx), 256'(10));

      // Block finished: extra beat is dropped, counter stays saturated
      send(to_sh(C_R1_IN, rnd128()), '0);
      chk_eq("post_drop_valid", 256'(out_valid), 256'(0));
      chk_eq("post_drop_ready", 256'(in_ready),  256'(1));
      chk_eq("post_drop_round", 256'(round_idx), 256'(10));

      // Backpressure: three back-to-back beats, all-zero state so output = key
      do_start();
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      sh_state_in = '0;
      sh_rkey_in  = to_sh(C_KA, 128'h0);
      @(posedge clk);
      #1;
      chk_eq("bp_ready_a", 256'(in_ready), 256'(1));
      sh_rkey_in = to_sh(C_KB, 128'h0);
      @(posedge clk);
      #1;
      chk_eq("bp_ready_b",  256'(in_ready),  256'(0));
      chk_eq("bp_valid_b",  256'(out_valid), 256'(1));
      chk_eq("bp_head_b",   256'(unmask(sh_state_out)), 256'(C_KA));
      sh_rkey_in = to_sh(C_KC, 128'h0);
      @(posedge clk);
      #1;
      chk_eq("bp_ready_c",  256'(in_ready), 256'(0));
      chk_eq("bp_head_c",   256'(unmask(sh_state_out)), 256'(C_KA));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_eq("bp_out2",     256'(unmask(sh_state_out)), 256'(C_KB));
      chk_eq("bp_out2_vld", 256'(out_valid), 256'(1));
      chk_eq("bp_ready_2",  256'(in_ready),  256'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk_eq("bp_out3",     256'(unmask(sh_state_out)), 256'(C_KC));
      chk_eq("bp_out3_vld", 256'(out_valid), 256'(1));
      @(posedge clk);
      #1;
      chk_eq("bp_drained",  256'(out_valid), 256'(0));

      // Asynchronous reset with both entries full
      do_start();
      out_ready = 1'b0;
      send(to_sh(C_R1_IN, rnd128()), '0);
      send(to_sh(C_R1_IN, rnd128()), '0);
      chk_eq("ar_full", 256'(in_ready), 256'(0));
      #2 nrst = 1'b0;
      #1;
      chk_eq("ar_valid", 256'(out_valid), 256'(0));
      chk_eq("ar_ready", 256'(in_ready),  256'(1));
      chk_eq("ar_round", 256'(round_idx), 256'(1));
      chk_eq("ar_last",  256'(out_last),  256'(0));
      @(posedge clk);
      #1 nrst   = 1'b1;
      out_ready = 1'b1;

      // Share isolation: share 0 all zero in state and key stays zero
      do_start();
      send(to_sh(C_R1_IN, C_R1_IN), to_sh(C_R1_KEY, C_R1_KEY));
      chk_eq("iso_share0", 256'(get_share(sh_state_out, 0)), 256'(0));
      chk_eq("iso_share1", 256'(get_share(sh_state_out, 1)), 256'(C_R1_OUT));

      // Random maskings of the same round-1 input
      for (int t = 0; t < 100; t++) begin
         do_start();
         send(to_sh(C_R1_IN, rnd128()), to_sh(C_R1_KEY, rnd128()));
         chk_eq($sformatf("mask_%0d", t), 256'(unmask(sh_state_out)), 256'(C_R1_OUT));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
